io_mmio_regs: RTL and testbench

//  Memory-mapped I/O register block between the CPU data-memory port and io_controller.
//  CPU stores set the 32-bit display word R_IO, which drives io_controller's seven-segment display.

---
 rtl/io_mmio_regs.sv | 116 +++++++++++
 tb/tb_io_mmio_regs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mmio_regs.sv
// io_mmio_regs: CPU memory-mapped register block for the display word and the four buttons.
// Ports: CLK/RST_N; we/re/addr/wdata -> rdata/rvalid; dBTNL/R/U/D in; R_IO, irq out.
module io_mmio_regs #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] DISP_RST = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic              dBTNL,
    input  logic              dBTNR,
    input  logic              dBTNU,
    input  logic              dBTND,
    output logic [31:0]       R_IO,
    output logic              irq
);

    localparam int IW = ADDR_W - 2;

    logic [3:0]       btn;
    logic [3:0]       sync1_q, sync2_q, prev_q;
    logic [3:0]       rise;
    logic [31:0]      disp_q, disp_d;
    logic [3:0]       evt_q, evt_d;
    logic [3:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;
    logic             irq_q;
    logic [2:0]       pop;
    logic [3:0]       w1c;
    logic [IW-1:0]    widx;
    logic             sel_disp, sel_lvl, sel_evt, sel_mask, sel_cnt;
    logic             unused_byte;

    assign btn = {dBTND, dBTNU, dBTNR, dBTNL};

    // Byte lanes are ignored; decode on the word index only.
    assign widx        = addr[ADDR_W-1:2];
    assign unused_byte = ^addr[1:0];

    assign sel_disp = (widx == IW'(0));
    assign sel_lvl  = (widx == IW'(1));
    assign sel_evt  = (widx == IW'(2));
    assign sel_mask = (widx == IW'(3));
    assign sel_cnt  = (widx == IW'(4));

    assign rise = sync2_q & ~prev_q;
    assign pop  = {2'b0, rise[0]} + {2'b0, rise[1]}
                + {2'b0, rise[2]} + {2'b0, rise[3]};

    assign w1c = (we && sel_evt) ? wdata[3:0] : 4'h0;

    always_comb begin
        disp_d = disp_q;
        mask_d = mask_q;
        if (we && sel_disp) disp_d = wdata;
        if (we && sel_mask) mask_d = wdata[3:0];
        // A rise in the same cycle as a clear keeps the flag set.
        evt_d = (evt_q & ~w1c) | rise;
        // Clearing write still counts presses arriving that cycle.
        if (we && sel_cnt) cnt_d = CNT_W'(pop);
        else               cnt_d = cnt_q + CNT_W'(pop);
    end

    // Read mux uses current state, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = 32'h0;
        unique case (1'b1)
            sel_disp: rdata_d = disp_q;
            sel_lvl:  rdata_d = {28'h0, sync2_q};
            sel_evt:  rdata_d = {28'h0, evt_q};
            sel_mask: rdata_d = {28'h0, mask_q};
            sel_cnt:  rdata_d = 32'(cnt_q);
            default:  rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q  <= 4'h0;
            sync2_q  <= 4'h0;
            prev_q   <= 4'h0;
            disp_q   <= DISP_RST;
            evt_q    <= 4'h0;
            mask_q   <= 4'h0;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            disp_q   <= disp_d;
            evt_q    <= evt_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            rvalid_q <= re;
            if (re) rdata_q <= rdata_d;
            irq_q    <= |(evt_d & mask_d);
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign R_IO   = disp_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_io_mmio_regs.sv
// tb_io_mmio_regs: vector table, directed corner sequences and random traffic
// compared every cycle against a behavioural model of the register block.
module tb_io_mmio_regs;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        we, re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic [3:0]  btn;
    logic [31:0] R_IO;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    io_mmio_regs dut (
        .CLK(CLK), .RST_N(RST_N), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .dBTNL(btn[0]), .dBTNR(btn[1]), .dBTNU(btn[2]), .dBTND(btn[3]),
        .R_IO(R_IO), .irq(irq)
    );

    // Model: button history (samples taken at each edge), register values.
    logic [3:0]  h [4];
    logic [31:0] m_disp, m_rdata;
    logic [3:0]  m_evt, m_mask;
    logic [15:0] m_cnt;
    logic        m_rvalid, m_irq;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (int'(a >> 2))
            0:       return m_disp;
            1:       return {28'h0, h[1]};
            2:       return {28'h0, m_evt};
            3:       return {28'h0, m_mask};
            4:       return {16'h0, m_cnt};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [3:0]  rise;
        logic [3:0]  clr;
        logic [31:0] rv;
        int          pop;
        int          wi;
        @(posedge CLK);
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) h[i] = 4'h0;
            m_disp = 32'h0; m_evt = 4'h0; m_mask = 4'h0; m_cnt = 16'h0;
            m_rdata = 32'h0; m_rvalid = 1'b0; m_irq = 1'b0;
        end else begin
            rv = m_read(addr);
            if (re) m_rdata = rv;
            m_rvalid = re;
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = btn;
            // A press is seen once the synchronised level goes 0 -> 1.
            rise = h[2] & ~h[3];
            pop = 0;
            for (int i = 0; i < 4; i++) pop += int'(rise[i]);
            wi = int'(addr >> 2);
            clr = (we && wi == 2) ? wdata[3:0] : 4'h0;
            m_evt = (m_evt & ~clr) | rise;
            if (we && wi == 4) m_cnt = 16'(pop);
            else               m_cnt = m_cnt + 16'(pop);
            if (we && wi == 0) m_disp = wdata;
            if (we && wi == 3) m_mask = wdata[3:0];
            m_irq = |(m_evt & m_mask);
        end
        #1;
        chk("rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
        chk("rdata", rdata, m_rdata);
        chk("R_IO", R_IO, m_disp);
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                      input string nm);
        re = 1'b1; addr = a;
        tick();
        re = 1'b0;
        chk({nm, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        chk(nm, rdata, exp);
    endtask

    typedef struct {
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{12'h000, 32'hDEAD_BEEF, 12'h000, 32'hDEAD_BEEF};
        tbl[1] = '{12'h00C, 32'hFFFF_FFFF, 12'h00C, 32'h0000_000F};
        tbl[2] = '{12'h004, 32'h1234_5678, 12'h004, 32'h0};
        tbl[3] = '{12'h014, 32'hFFFF_FFFF, 12'h000, 32'hDEAD_BEEF};
        tbl[4] = '{12'h400, 32'h0, 12'h000, 32'hDEAD_BEEF};
        tbl[5] = '{12'h003, 32'h1122_3344, 12'h001, 32'h1122_3344};
        tbl[6] = '{12'h00D, 32'h5, 12'h00C, 32'h5};
        tbl[7] = '{12'h00C, 32'h0, 12'h014, 32'h0};

        RST_N = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; btn = '0;
        ticks(2);
        RST_N = 1'b1;
        tick();
        chk("rst_R_IO", R_IO, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        rd(12'h000, 32'h0, "rst_disp");
        rd(12'h008, 32'h0, "rst_evt");
        rd(12'h00C, 32'h0, "rst_mask");
        rd(12'h010, 32'h0, "rst_cnt");

        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].wa, tbl[i].wd);
            if (i == 0) chk("disp_next", R_IO, 32'hDEAD_BEEF);
            rd(tbl[i].ra, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Same-cycle write and read returns the old value.
        we = 1'b1; re = 1'b1; addr = 12'h000; wdata = 32'hCAFE_F00D;
        tick();
        we = 1'b0; re = 1'b0;
        chk("rw_old", rdata, 32'h1122_3344);
        chk("rw_new", R_IO, 32'hCAFE_F00D);

        // Up press: three cycles to EVENT, held level counts once.
        btn = 4'b0100;
        ticks(3);
        rd(12'h008, 32'h4, "up_evt");
        rd(12'h010, 32'h1, "up_cnt");
        rd(12'h004, 32'h4, "up_lvl");
        ticks(5);
        rd(12'h010, 32'h1, "up_hold");

        // Mask enables irq; W1C drops it.
        wr(12'h00C, 32'h4);
        chk("irq_on", {31'h0, irq}, 32'h1);
        wr(12'h008, 32'h4);
        chk("irq_off", {31'h0, irq}, 32'h0);
        rd(12'h008, 32'h0, "w1c_evt");

        // W1C colliding with a new left rise keeps the flag.
        btn = 4'b0001;
        ticks(3);
        btn = 4'b0000;
        ticks(3);
        btn = 4'b0001;
        ticks(2);
        wr(12'h008, 32'h1);
        rd(12'h008, 32'h1, "col_evt");
        rd(12'h010, 32'h3, "col_cnt");
        btn = 4'b0000;
        ticks(3);

        // Drive counter to 0xFFFF, then one more press wraps to 0.
        wr(12'h010, 32'h0);
        wr(12'h008, 32'hF);
        for (int i = 0; i < 16383; i++) begin
            btn = 4'hF; tick();
            btn = 4'h0; tick();
        end
        for (int i = 0; i < 3; i++) begin
            btn = 4'h1; tick();
            btn = 4'h0; tick();
        end
        ticks(4);
        rd(12'h010, 32'h0000_FFFF, "cnt_max");
        rd(12'h008, 32'hF, "evt_all");
        btn = 4'h1; tick();
        btn = 4'h0; ticks(4);
        rd(12'h010, 32'h0, "cnt_wrap");

        // Reset while a read is requested drops it.
        wr(12'h00C, 32'hF);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        re = 1'b1; addr = 12'h008; RST_N = 1'b0;
        tick();
        re = 1'b0;
        chk("rst_drop", {31'h0, rvalid}, 32'h0);
        tick();
        RST_N = 1'b1;
        tick();
        chk("rst2_irq", {31'h0, irq}, 32'h0);
        rd(12'h000, 32'h0, "rst2_disp");
        rd(12'h008, 32'h0, "rst2_evt");
        rd(12'h00C, 32'h0, "rst2_mask");
        rd(12'h010, 32'h0, "rst2_cnt");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k <= 4)      addr = 12'(k * 4 + $urandom_range(0, 3));
            else if (k == 5) addr = 12'h014;
            else             addr = 12'($urandom_range(0, 4095));
            we    = ($urandom_range(0, 3) == 0);
            re    = ($urandom_range(0, 2) == 0);
            wdata = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            tick();
        end
        we = 1'b0; re = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
